// File: rtl/synchronous_fifo_pkg.sv
// Shared definitions for the synchronous FIFO family.
package synchronous_fifo_pkg;

   // Advance a circular pointer over 0..size-1 without assuming a power-of-two size.
   function automatic int next_ptr(input int ptr, input int size);
      return (ptr == size - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/synchronous_fifo_level.sv
// Occupancy tracking: count, high-water mark, almost flags and the
// registered handshake qualifiers derived from next-count.
module synchronous_fifo_level #(
   parameter int depth    = 4,
   parameter int size     = 16,
   parameter int ae_level = 2,
   parameter int af_level = 14
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           flush,
   input  logic           wr_fire,
   input  logic           rd_fire,
   output logic [depth:0] count,
   output logic [depth:0] high_water,
   output logic           almost_empty,
   output logic           almost_full,
   output logic           din_ready,
   output logic           dout_valid
);
   localparam int lvl_w = depth + 1;
   localparam logic [depth:0] size_lvl = lvl_w'(size);
   localparam logic [depth:0] ae_lvl   = lvl_w'(ae_level);
   localparam logic [depth:0] af_lvl   = lvl_w'(af_level);
   localparam logic [depth:0] one_lvl  = lvl_w'(1);

   logic [depth:0] count_reg, count_next;
   logic [depth:0] high_water_reg, high_water_next;
   logic           almost_empty_reg, almost_full_reg;
   logic           din_ready_reg, dout_valid_reg;

   // Next occupancy: simultaneous read and write cancel out.
   always_comb begin
      count_next = count_reg;
      case ({wr_fire, rd_fire})
         2'b10:   count_next = count_reg + one_lvl;
         2'b01:   count_next = count_reg - one_lvl;
         default: count_next = count_reg;
      endcase
      high_water_next = (count_next > high_water_reg) ? count_next : high_water_reg;
   end

   // All level outputs register from next-count so they stay aligned with count.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         count_reg        <= '0;
         high_water_reg   <= '0;
         almost_empty_reg <= 1'b1;
         almost_full_reg  <= 1'b0;
         din_ready_reg    <= 1'b1;
         dout_valid_reg   <= 1'b0;
      end else begin
         count_reg        <= count_next;
         high_water_reg   <= high_water_next;
         almost_empty_reg <= (count_next <= ae_lvl);
         almost_full_reg  <= (count_next >= af_lvl);
         din_ready_reg    <= (count_next != size_lvl);
         dout_valid_reg   <= (count_next != '0);
      end
   end

   assign count        = count_reg;
   assign high_water   = high_water_reg;
   assign almost_empty = almost_empty_reg;
   assign almost_full  = almost_full_reg;
   assign din_ready    = din_ready_reg;
   assign dout_valid   = dout_valid_reg;

endmodule

// File: rtl/synchronous_fifo.sv
// Single-clock first-word-fall-through FIFO with arbitrary capacity,
// live level, almost flags, synchronous flush and high-water mark.
module synchronous_fifo
   import synchronous_fifo_pkg::*;
#(
   parameter int width    = 8,
   parameter int depth    = 4,
   parameter int size     = 16,
   parameter int ae_level = 2,
   parameter int af_level = 14
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic [width-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic [width-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic [depth:0]   count,
   output logic             almost_empty,
   output logic             almost_full,
   output logic [depth:0]   high_water
);
   // Reject parameter sets that cannot describe a working FIFO.
   if (size < 2 || size > (1 << depth) || ae_level < 0 ||
       ae_level >= af_level || af_level > size) begin : g_bad_params
      $error("synchronous_fifo: illegal width/depth/size/ae_level/af_level combination");
   end

   logic [width-1:0] mem [size];
   logic [depth-1:0] wr_ptr_reg, wr_ptr_next;
   logic [depth-1:0] rd_ptr_reg, rd_ptr_next;
   logic             wr_fire, rd_fire;

   // Flush and reset drop any coincident transfer, including the storage write.
   assign wr_fire = din_valid & din_ready & ~flush & ~reset;
   assign rd_fire = dout_valid & dout_ready & ~flush & ~reset;

   // Pointer successors wrap at size-1.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      if (wr_fire) wr_ptr_next = depth'(next_ptr(32'(wr_ptr_reg), size));
      if (rd_fire) rd_ptr_next = depth'(next_ptr(32'(rd_ptr_reg), size));
   end

   // Pointer registers; flush rewinds them like reset.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
      end
   end

   // Storage write; contents are never cleared, validity comes from count.
   always_ff @(posedge clock) begin
      if (wr_fire) mem[wr_ptr_reg] <= din;
   end

   // Head is read combinationally and masked when the FIFO is empty.
   assign dout = dout_valid ? mem[rd_ptr_reg] : '0;

   synchronous_fifo_level #(
      .depth    (depth),
      .size     (size),
      .ae_level (ae_level),
      .af_level (af_level)
   ) u_level (
      .clock        (clock),
      .reset        (reset),
      .flush        (flush),
      .wr_fire      (wr_fire),
      .rd_fire      (rd_fire),
      .count        (count),
      .high_water   (high_water),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .din_ready    (din_ready),
      .dout_valid   (dout_valid)
   );

endmodule

// File: tb/tb_synchronous_fifo.sv
// Scoreboard bench for synchronous_fifo (non-power-of-two size of 12).
module tb_synchronous_fifo;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int SIZE  = 12;
   localparam int AE    = 2;
   localparam int AF    = 10;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             flush = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic             din_valid = 1'b0;
   logic             din_ready;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready = 1'b0;
   logic [DEPTH:0]   count;
   logic             almost_empty;
   logic             almost_full;
   logic [DEPTH:0]   high_water;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [WIDTH-1:0] sb_q [$];
   int               m_hw = 0;

   synchronous_fifo #(
      .width(WIDTH), .depth(DEPTH), .size(SIZE), .ae_level(AE), .af_level(AF)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .flush        (flush),
      .din          (din),
      .din_valid    (din_valid),
      .din_ready    (din_ready),
      .dout         (dout),
      .dout_valid   (dout_valid),
      .dout_ready   (dout_ready),
      .count        (count),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .high_water   (high_water)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Compare every output with the model, then apply one clock edge.
   task automatic step(input logic wv, input logic [WIDTH-1:0] d, input logic rr);
      int  m_cnt;
      logic wf, rf;
      logic [WIDTH-1:0] head;
      din_valid  = wv;
      din        = d;
      dout_ready = rr;
      m_cnt = sb_q.size();
      head  = (m_cnt != 0) ? sb_q[0] : '0;
      check("count",        32'(count),        32'(m_cnt));
      check("din_ready",    32'(din_ready),    32'(m_cnt != SIZE));
      check("dout_valid",   32'(dout_valid),   32'(m_cnt != 0));
      check("dout",         32'(dout),         32'(head));
      check("almost_empty", 32'(almost_empty), 32'(m_cnt <= AE));
      check("almost_full",  32'(almost_full),  32'(m_cnt >= AF));
      check("high_water",   32'(high_water),   32'(m_hw));
      wf = wv && (m_cnt != SIZE);
      rf = rr && (m_cnt != 0);
      @(posedge clock);
      #1;
      cyc++;
      if (reset || flush) begin
         sb_q.delete();
         m_hw = 0;
         $display("cycle %0d: %s (wr=%0b rd=%0b dropped)", cyc, reset ? "reset" : "flush", wf, rf);
      end else begin
         if (rf) void'(sb_q.pop_front());
         if (wf) sb_q.push_back(d);
         if (sb_q.size() > m_hw) m_hw = sb_q.size();
         if (wf || rf)
            $display("cycle %0d: wr=%0b data=%02h rd=%0b data=%02h level=%0d",
                     cyc, wf, d, rf, head, sb_q.size());
      end
   endtask

   initial begin
      int pw, pr;
      // Bring the design out of reset with a known model state.
      reset = 1'b1;
      @(posedge clock);
      #1;
      step(1'b0, '0, 1'b0);
      reset = 1'b0;

      // Idle reset values, then a single write visible the next cycle.
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b1, 8'hA5, 1'b0);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1);

      // Fill to capacity, then read with writes held to exercise wrap and din_ready recovery.
      for (int i = 1; i <= SIZE + 2; i++) step(1'b1, 8'(i), 1'b0);
      for (int i = 0; i < SIZE + 4; i++) step(1'b1, 8'(8'h40 + i), 1'b1);
      for (int i = 0; i < SIZE + 2; i++) step(1'b0, '0, 1'b1);

      // Steady level 3 with read and write every cycle after a flush clears high_water.
      flush = 1'b1; step(1'b0, '0, 1'b0); flush = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
      for (int i = 0; i < 100; i++) step(1'b1, 8'(8'h80 + i), 1'b1);

      // Flush at level 6 with a coincident write and read.
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
      flush = 1'b1; step(1'b1, 8'hEE, 1'b1); flush = 1'b0;
      step(1'b0, '0, 1'b0);

      // Reset mid-burst at level 9, then an immediate write after release.
      for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
      step(1'b1, 8'h50, 1'b1);
      reset = 1'b1; step(1'b1, 8'h51, 1'b1); reset = 1'b0;
      step(1'b1, 8'h5A, 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);

      // Random stalls on both sides with varying pressure.
      for (int i = 0; i < 10000; i++) begin
         case ((i / 1000) % 4)
            0:       begin pw = 80; pr = 30; end
            1:       begin pw = 30; pr = 80; end
            2:       begin pw = 95; pr = 95; end
            default: begin pw = 50; pr = 50; end
         endcase
         step(1'($urandom_range(0, 99) < pw), 8'($urandom), 1'($urandom_range(0, 99) < pr));
      end
      for (int i = 0; i < SIZE + 1; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
